// File: rtl/ctrl_sequencer.sv
// Multi-step control sequencer for the ALU/register-file bus: latches an instruction, steps T0..T3.
// Optional CTRL_ILLEGAL_EN adds a sticky ILL flag for undefined opcodes.
module ctrl_sequencer #(
  parameter int DW   = 10,
  parameter int NREG = 8
) (
  input  logic            CLKb,
  input  logic            RSTb,
  input  logic            PEI,
  input  logic [DW-1:0]   INSTR,
  output logic            IRin,
  output logic [NREG-1:0] Rin,
  output logic [NREG-1:0] Rout,
  output logic            ENW,
  output logic            Ain,
  output logic            Gin,
  output logic            Gout,
  output logic [3:0]      FN,
  output logic            Done,
  output logic [1:0]      STEP
`ifdef CTRL_ILLEGAL_EN
  ,
  output logic            ILL
`endif
);

  // state | meaning
  // T0    | idle, IRin=PEI, latch INSTR on PEI
  // T1    | first execute step (LOAD/COPY/undefined finish here)
  // T2    | second step (B-only ops finish here)
  // T3    | third step (two-operand ALU ops finish here)
  localparam logic [1:0] T0 = 2'd0;
  localparam logic [1:0] T1 = 2'd1;
  localparam logic [1:0] T2 = 2'd2;
  localparam logic [1:0] T3 = 2'd3;

  localparam logic [3:0] LOAD = 4'b0000;
  localparam logic [3:0] COPY = 4'b0001;
  localparam logic [3:0] ADD  = 4'b0010;
  localparam logic [3:0] SUB  = 4'b0011;
  localparam logic [3:0] INV  = 4'b0100;
  localparam logic [3:0] FLP  = 4'b0101;
  localparam logic [3:0] AND  = 4'b0110;
  localparam logic [3:0] OR   = 4'b0111;
  localparam logic [3:0] XOR  = 4'b1000;
  localparam logic [3:0] LSL  = 4'b1001;
  localparam logic [3:0] LSR  = 4'b1010;
  localparam logic [3:0] ASR  = 4'b1011;

  logic [DW-1:0]   ir;
  logic [1:0]      step;
  logic [1:0]      step_nxt;
  logic [3:0]      op;
  logic [2:0]      rx, ry;
  logic [NREG-1:0] rx_1h, ry_1h;
  logic            two_op, b_only;
  logic            irin_c, enw_c, ain_c, gin_c, gout_c, done_c, advance;
  logic [NREG-1:0] rin_c, rout_c;
  logic [3:0]      fn_c;

  assign op     = ir[9:6];
  assign rx     = ir[5:3];
  assign ry     = ir[2:0];
  assign rx_1h  = {{(NREG-1){1'b0}}, 1'b1} << rx;
  assign ry_1h  = {{(NREG-1){1'b0}}, 1'b1} << ry;
  assign two_op = op inside {ADD, SUB, AND, OR, XOR, LSL, LSR, ASR};
  assign b_only = op inside {INV, FLP};

  always_comb begin
    irin_c  = 1'b0;
    rin_c   = '0;
    rout_c  = '0;
    enw_c   = 1'b0;
    ain_c   = 1'b0;
    gin_c   = 1'b0;
    gout_c  = 1'b0;
    fn_c    = 4'b0000;
    done_c  = 1'b0;
    advance = 1'b0;
    case (step)
      T0: irin_c = PEI;
      T1: begin
        if (op == LOAD) begin
          enw_c  = 1'b1;
          rin_c  = rx_1h;
          done_c = 1'b1;
        end else if (op == COPY) begin
          rout_c = ry_1h;
          rin_c  = rx_1h;
          done_c = 1'b1;
        end else if (two_op) begin
          rout_c  = rx_1h;
          ain_c   = 1'b1;
          advance = 1'b1;
        end else if (b_only) begin
          rout_c  = ry_1h;
          fn_c    = op;
          gin_c   = 1'b1;
          advance = 1'b1;
        end else begin
          done_c = 1'b1;
        end
      end
      T2: begin
        if (two_op) begin
          rout_c  = ry_1h;
          fn_c    = op;
          gin_c   = 1'b1;
          advance = 1'b1;
        end else if (b_only) begin
          gout_c = 1'b1;
          rin_c  = rx_1h;
          done_c = 1'b1;
        end
      end
      default: begin
        if (two_op) begin
          gout_c = 1'b1;
          rin_c  = rx_1h;
          done_c = 1'b1;
        end
      end
    endcase
  end

  // Anything that neither advances nor starts from T0 (Done or an illegal combination) lands in T0.
  always_comb begin
    step_nxt = T0;
    if (step == T0)
      step_nxt = PEI ? T1 : T0;
    else if (advance)
      step_nxt = step + 2'd1;
  end

  always_ff @(negedge CLKb or negedge RSTb) begin
    if (!RSTb) begin
      ir   <= '0;
      step <= T0;
    end else begin
      if (step == T0 && PEI)
        ir <= INSTR;
      step <= step_nxt;
    end
  end

`ifdef CTRL_ILLEGAL_EN
  always_ff @(negedge CLKb or negedge RSTb) begin
    if (!RSTb)
      ILL <= 1'b0;
    else if (step == T1 && op[3:2] == 2'b11)
      ILL <= 1'b1;
  end
`endif

  assign IRin = irin_c & RSTb;
  assign Rin  = rin_c & {NREG{RSTb}};
  assign Rout = rout_c & {NREG{RSTb}};
  assign ENW  = enw_c & RSTb;
  assign Ain  = ain_c & RSTb;
  assign Gin  = gin_c & RSTb;
  assign Gout = gout_c & RSTb;
  assign FN   = fn_c & {4{RSTb}};
  assign Done = done_c & RSTb;
  assign STEP = step & {2{RSTb}};

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Scoreboard bench for ctrl_sequencer: expected per-step output vectors are queued, then compared each cycle.
module tb_ctrl_sequencer;

  logic       CLKb = 1'b1;
  logic       RSTb;
  logic       PEI;
  logic [9:0] INSTR;
  logic       IRin, ENW, Ain, Gin, Gout, Done;
  logic [7:0] Rin, Rout;
  logic [3:0] FN;
  logic [1:0] STEP;
`ifdef CTRL_ILLEGAL_EN
  logic       ILL;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];

  ctrl_sequencer dut (
    .CLKb(CLKb), .RSTb(RSTb), .PEI(PEI), .INSTR(INSTR),
    .IRin(IRin), .Rin(Rin), .Rout(Rout), .ENW(ENW), .Ain(Ain),
    .Gin(Gin), .Gout(Gout), .FN(FN), .Done(Done), .STEP(STEP)
`ifdef CTRL_ILLEGAL_EN
    , .ILL(ILL)
`endif
  );

  always #5 CLKb = ~CLKb;

  function automatic logic [31:0] obs();
    return {4'b0, IRin, Rin, Rout, ENW, Ain, Gin, Gout, FN, Done, STEP};
  endfunction

  function automatic logic [31:0] mk(input logic irin, input logic [7:0] rin, input logic [7:0] rout,
                                     input logic enw, input logic ain, input logic gin, input logic gout,
                                     input logic [3:0] fn, input logic done, input logic [1:0] step);
    return {4'b0, irin, rin, rout, enw, ain, gin, gout, fn, done, step};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called just after a negedge: apply inputs, compare at posedge, return after next negedge.
  task automatic cyc(input logic pei, input logic [9:0] ins, input string tag);
    PEI = pei;
    INSTR = ins;
    @(posedge CLKb);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got %h expected <scoreboard empty>", tag, obs());
    end else begin
      chk(tag, obs(), sb.pop_front());
    end
    @(negedge CLKb);
    #1;
  endtask

  localparam logic [31:0] IDLE  = 32'h0;
  localparam logic [9:0]  I_LD3 = 10'b0000_011_000;
  localparam logic [9:0]  I_ADD = 10'b0010_001_010;
  localparam logic [9:0]  I_INV = 10'b0100_101_110;
  localparam logic [9:0]  I_CPY = 10'b0001_100_111;
  localparam logic [9:0]  I_UND = 10'b1110_010_011;
  localparam logic [9:0]  I_AA  = 10'b0010_011_011;
  localparam logic [9:0]  I_ASR = 10'b1011_000_111;

  initial begin
    RSTb = 1'b0;
    PEI = 1'b1;
    INSTR = I_ADD;
    #12;
    chk("reset_outputs", obs(), IDLE);
`ifdef CTRL_ILLEGAL_EN
    chk("reset_ill", {31'b0, ILL}, 32'd0);
`endif
    @(posedge CLKb); #1;
    RSTb = 1'b1;
    PEI = 1'b0;
    @(negedge CLKb); #1;

    sb.push_back(IDLE);
    cyc(1'b0, I_LD3, "idle");

    // LOAD R3
    sb.push_back(mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 4'h0, 0, 2'd0));
    sb.push_back(mk(0, 8'h08, 8'h00, 1, 0, 0, 0, 4'h0, 1, 2'd1));
    sb.push_back(IDLE);
    cyc(1'b1, I_LD3, "load_t0");
    cyc(1'b0, 10'h3ff, "load_t1");
    cyc(1'b0, I_LD3, "load_back_t0");

    // ADD R1,R2 with PEI toggling during T1-T3
    sb.push_back(mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 4'h0, 0, 2'd0));
    sb.push_back(mk(0, 8'h00, 8'h02, 0, 1, 0, 0, 4'h0, 0, 2'd1));
    sb.push_back(mk(0, 8'h00, 8'h04, 0, 0, 1, 0, 4'h2, 0, 2'd2));
    sb.push_back(mk(0, 8'h02, 8'h00, 0, 0, 0, 1, 4'h0, 1, 2'd3));
    sb.push_back(IDLE);
    cyc(1'b1, I_ADD, "add_t0");
    cyc(1'b1, I_INV, "add_t1");
    cyc(1'b0, I_LD3, "add_t2");
    cyc(1'b1, I_CPY, "add_t3");
    cyc(1'b0, I_ADD, "add_idle");

    // INV R5,R6
    sb.push_back(mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 4'h0, 0, 2'd0));
    sb.push_back(mk(0, 8'h00, 8'h40, 0, 0, 1, 0, 4'h4, 0, 2'd1));
    sb.push_back(mk(0, 8'h20, 8'h00, 0, 0, 0, 1, 4'h0, 1, 2'd2));
    sb.push_back(IDLE);
    cyc(1'b1, I_INV, "inv_t0");
    cyc(1'b0, I_INV, "inv_t1");
    cyc(1'b0, I_INV, "inv_t2");
    cyc(1'b0, I_INV, "inv_idle");

    // Back-to-back ADD then COPY R4,R7 with PEI held high
    sb.push_back(mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 4'h0, 0, 2'd0));
    sb.push_back(mk(0, 8'h00, 8'h02, 0, 1, 0, 0, 4'h0, 0, 2'd1));
    sb.push_back(mk(0, 8'h00, 8'h04, 0, 0, 1, 0, 4'h2, 0, 2'd2));
    sb.push_back(mk(0, 8'h02, 8'h00, 0, 0, 0, 1, 4'h0, 1, 2'd3));
    sb.push_back(mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 4'h0, 0, 2'd0));
    sb.push_back(mk(0, 8'h10, 8'h80, 0, 0, 0, 0, 4'h0, 1, 2'd1));
    sb.push_back(IDLE);
    cyc(1'b1, I_ADD, "b2b_add_t0");
    cyc(1'b1, I_CPY, "b2b_add_t1");
    cyc(1'b1, I_CPY, "b2b_add_t2");
    cyc(1'b1, I_CPY, "b2b_add_t3");
    cyc(1'b1, I_CPY, "b2b_cpy_t0");
    cyc(1'b0, I_CPY, "b2b_cpy_t1");
    cyc(1'b0, I_CPY, "b2b_idle");

    // Undefined opcode 1110
    sb.push_back(mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 4'h0, 0, 2'd0));
    sb.push_back(mk(0, 8'h00, 8'h00, 0, 0, 0, 0, 4'h0, 1, 2'd1));
    sb.push_back(IDLE);
    cyc(1'b1, I_UND, "und_t0");
`ifdef CTRL_ILLEGAL_EN
    chk("ill_before_end_t1", {31'b0, ILL}, 32'd0);
`endif
    cyc(1'b0, I_UND, "und_t1");
`ifdef CTRL_ILLEGAL_EN
    chk("ill_set", {31'b0, ILL}, 32'd1);
`endif
    cyc(1'b0, I_UND, "und_idle");

    // Rx == Ry: ADD R3,R3
    sb.push_back(mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 4'h0, 0, 2'd0));
    sb.push_back(mk(0, 8'h00, 8'h08, 0, 1, 0, 0, 4'h0, 0, 2'd1));
    sb.push_back(mk(0, 8'h00, 8'h08, 0, 0, 1, 0, 4'h2, 0, 2'd2));
    sb.push_back(mk(0, 8'h08, 8'h00, 0, 0, 0, 1, 4'h0, 1, 2'd3));
    cyc(1'b1, I_AA, "same_t0");
    cyc(1'b0, I_AA, "same_t1");
    cyc(1'b0, I_AA, "same_t2");
    cyc(1'b0, I_AA, "same_t3");

    // ASR R0,R7 (highest ALU code)
    sb.push_back(mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 4'h0, 0, 2'd0));
    sb.push_back(mk(0, 8'h00, 8'h01, 0, 1, 0, 0, 4'h0, 0, 2'd1));
    sb.push_back(mk(0, 8'h00, 8'h80, 0, 0, 1, 0, 4'hb, 0, 2'd2));
    sb.push_back(mk(0, 8'h01, 8'h00, 0, 0, 0, 1, 4'h0, 1, 2'd3));
    cyc(1'b1, I_ASR, "asr_t0");
    cyc(1'b0, I_ASR, "asr_t1");
    cyc(1'b0, I_ASR, "asr_t2");
    cyc(1'b0, I_ASR, "asr_t3");
`ifdef CTRL_ILLEGAL_EN
    chk("ill_sticky", {31'b0, ILL}, 32'd1);
`endif

    // Reset in T2 of an ADD
    sb.push_back(mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 4'h0, 0, 2'd0));
    sb.push_back(mk(0, 8'h00, 8'h02, 0, 1, 0, 0, 4'h0, 0, 2'd1));
    cyc(1'b1, I_ADD, "rst_add_t0");
    cyc(1'b0, I_ADD, "rst_add_t1");
    chk("pre_rst_step", {30'b0, STEP}, 32'd2);
    PEI = 1'b1;
    RSTb = 1'b0;
    #1;
    chk("rst_mid_outputs", obs(), IDLE);
`ifdef CTRL_ILLEGAL_EN
    chk("rst_ill_clear", {31'b0, ILL}, 32'd0);
`endif
    @(negedge CLKb); #1;
    chk("rst_held_outputs", obs(), IDLE);
    @(posedge CLKb); #1;
    RSTb = 1'b1;
    PEI = 1'b0;
    @(negedge CLKb); #1;
    sb.push_back(IDLE);
    sb.push_back(IDLE);
    cyc(1'b0, I_ADD, "post_rst_idle0");
    cyc(1'b0, I_ADD, "post_rst_idle1");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
